var_mod_counter: RTL

Parametrised successor to the single-digit variable-modulus counter. It counts ticks derived from the board clock, with a run-time modulus, an up/down direction, enable and synchronous clear. It emits a wrap carry pulse and drives DIGITS active-low 7-segment hexadecimal displays. It sits between the board switches/keys and the HEX outputs, and is the generic counter/display block for later labs.

---
 rtl/seg7_pkg.sv | 32 +++
 rtl/seg7_decode.sv | 15 +
 rtl/var_mod_counter.sv | 107 ++++++++++
 3 files changed

// File: rtl/seg7_pkg.sv
// Shared 7-segment constants and the hex-to-segment lookup used by the display
// decoders. Patterns are active-low, bit order gfedcba.
package seg7_pkg;

    // All segments dark.
    localparam logic [6:0] SEG_BLANK = 7'b1111111;

    // Hex digit patterns, entry k is the pattern for nibble value k.
    localparam logic [15:0][6:0] SEG_HEX_TABLE = {
        7'b0001110,  // F
        7'b0000110,  // E
        7'b0100001,  // d
        7'b1000110,  // C
        7'b0000011,  // b
        7'b0001000,  // A
        7'b0011000,  // 9
        7'b0000000,  // 8
        7'b1111000,  // 7
        7'b0000010,  // 6
        7'b0010010,  // 5
        7'b0011001,  // 4
        7'b0110000,  // 3
        7'b0100100,  // 2
        7'b1111001,  // 1
        7'b1000000   // 0
    };

    function automatic logic [6:0] seg7_hex(input logic [3:0] nibble);
        return SEG_HEX_TABLE[nibble];
    endfunction

endpackage

// File: rtl/seg7_decode.sv
// One hex digit of a 7-segment display: 4-bit nibble in, active-low gfedcba out.
// Purely combinational.
module seg7_decode
    import seg7_pkg::*;
(
    input  logic [3:0] i_nibble,
    output logic [6:0] o_seg
);

    // Table lookup of the active-low segment pattern.
    always_comb begin
        o_seg = seg7_hex(i_nibble);
    end

endmodule

// File: rtl/var_mod_counter.sv
// Variable-modulus up/down counter with a free-running tick divider, wrap carry
// pulse and DIGITS active-low hex displays of the count. The tick is used as a
// clock enable; no derived clock exists.
module var_mod_counter
    import seg7_pkg::*;
#(
    parameter int CLK_FREQ = 50_000_000,
    parameter int TICK_HZ  = 1,
    parameter int WIDTH    = 8,
    parameter int DIGITS   = 2
)
(
    input  logic                  clk_50m,
    input  logic                  rst_n,
    input  logic                  en,
    input  logic                  clr,
    input  logic                  dir,
    input  logic [WIDTH-1:0]      modulus,
    output logic [WIDTH-1:0]      count,
    output logic                  carry,
    output logic                  tick,
    output logic [7*DIGITS-1:0]   hex
);

    // DIV must be at least 2 and 4*DIGITS must cover WIDTH.
    localparam int DIV   = CLK_FREQ / TICK_HZ;
    localparam int DIV_W = $clog2(DIV);
    localparam int NIB_W = 4 * DIGITS;

    logic [DIV_W-1:0] r_div;
    logic [WIDTH-1:0] r_count;
    logic             r_carry;
    logic             w_tick;
    logic [WIDTH-1:0] w_mod_eff;
    logic [WIDTH-1:0] w_top;
    logic [NIB_W-1:0] w_nibbles;

    // Tick is the last divider state; modulus below 2 is treated as 2.
    always_comb begin
        w_tick    = (r_div == DIV_W'(DIV - 1));
        w_mod_eff = (modulus < WIDTH'(2)) ? WIDTH'(2) : modulus;
        w_top     = w_mod_eff - WIDTH'(1);
    end

    // Free-running divider 0..DIV-1; clr restarts it so the next tick is a full period away.
    always_ff @(posedge clk_50m or negedge rst_n) begin
        if (!rst_n) begin
            r_div <= '0;
        end else if (clr || w_tick) begin
            r_div <= '0;
        end else begin
            r_div <= r_div + DIV_W'(1);
        end
    end

    // Count update on enabled ticks; carry is a one-cycle pulse on wrap only.
    always_ff @(posedge clk_50m or negedge rst_n) begin
        if (!rst_n) begin
            r_count <= '0;
            r_carry <= 1'b0;
        end else begin
            r_carry <= 1'b0;
            if (clr) begin
                r_count <= '0;
            end else if (w_tick && en) begin
                if (dir) begin
                    if (r_count >= w_top) begin
                        r_count <= '0;
                        r_carry <= 1'b1;
                    end else begin
                        r_count <= r_count + WIDTH'(1);
                    end
                end else begin
                    if (r_count == '0) begin
                        r_count <= w_top;
                        r_carry <= 1'b1;
                    end else if (r_count > w_top) begin
                        // Modulus was lowered below the current count: clamp without carry.
                        r_count <= w_top;
                    end else begin
                        r_count <= r_count - WIDTH'(1);
                    end
                end
            end
        end
    end

    // Zero-extend the count so unused upper nibbles display "0".
    always_comb begin
        w_nibbles = NIB_W'(r_count);
    end

    assign count = r_count;
    assign carry = r_carry;
    assign tick  = w_tick;

    genvar k;
    generate
        for (k = 0; k < DIGITS; k++) begin : g_digit
            seg7_decode u_dec (
                .i_nibble (w_nibbles[4*k +: 4]),
                .o_seg    (hex[7*k +: 7])
            );
        end
    endgenerate

endmodule
